// File: rtl/conv_tap_sequencer.sv
// Tap sequencer for a single MAC PE: walks the K x K x CH window of every output
// pixel of one IFM tile, drives SRAM reads and PE enables, and hands out psums.
module conv_tap_sequencer #(
    parameter int K_SIZE     = 3,
    parameter int IFM_W      = 16,
    parameter int IFM_H      = 16,
    parameter int CH         = 4,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] ifm_addr,
    output logic [ADDR_WIDTH-1:0] wgt_addr,
    output logic                  set_reg,
    output logic                  pe_first,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr
);
    localparam int OW = IFM_W - K_SIZE + 1;
    localparam int OH = IFM_H - K_SIZE + 1;
    localparam int KW = $clog2(K_SIZE + 1);
    localparam int CW = $clog2(CH + 1);
    localparam int XW = $clog2(OW + 1);
    localparam int YW = $clog2(OH + 1);

    localparam logic [KW-1:0] K_LAST  = KW'(K_SIZE - 1);
    localparam logic [KW-1:0] K_ONE   = KW'(1);
    localparam logic [KW-1:0] K_ZERO  = KW'(0);
    localparam logic [CW-1:0] C_LAST  = CW'(CH - 1);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_ZERO  = CW'(0);
    localparam logic [XW-1:0] OX_LAST = XW'(OW - 1);
    localparam logic [XW-1:0] OX_ONE  = XW'(1);
    localparam logic [XW-1:0] OX_ZERO = XW'(0);
    localparam logic [YW-1:0] OY_LAST = YW'(OH - 1);
    localparam logic [YW-1:0] OY_ONE  = YW'(1);
    localparam logic [YW-1:0] OY_ZERO = YW'(0);

    localparam logic [ADDR_WIDTH-1:0] A_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
    // Address jumps when kx wraps, when ky wraps, and when ox wraps to a new row.
    localparam logic [ADDR_WIDTH-1:0] STEP_ROW = ADDR_WIDTH'(IFM_W - K_SIZE + 1);
    localparam logic [ADDR_WIDTH-1:0] STEP_CH  =
        ADDR_WIDTH'(IFM_H * IFM_W - (K_SIZE - 1) * IFM_W - (K_SIZE - 1));
    localparam logic [ADDR_WIDTH-1:0] STEP_PIX_ROW = ADDR_WIDTH'(K_SIZE);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_LAT  = 3'd2,
        S_OUT  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t                r_state;
    logic [KW-1:0]         r_kx;
    logic [KW-1:0]         r_ky;
    logic [CW-1:0]         r_c;
    logic [XW-1:0]         r_ox;
    logic [YW-1:0]         r_oy;
    logic [ADDR_WIDTH-1:0] r_pix_base;
    logic [ADDR_WIDTH-1:0] r_ifm_addr;
    logic [ADDR_WIDTH-1:0] r_wgt_addr;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_rd_en;
    logic                  r_set_reg;
    logic                  r_pe_first;
    logic                  r_out_valid;

    logic                  w_first_tap;
    logic                  w_last_pix;
    logic [ADDR_WIDTH-1:0] w_next_pix;

    assign w_first_tap = (r_kx == K_ZERO) && (r_ky == K_ZERO) && (r_c == C_ZERO);
    assign w_last_pix  = (r_ox == OX_LAST) && (r_oy == OY_LAST);
    assign w_next_pix  = (r_ox == OX_LAST) ? (r_pix_base + STEP_PIX_ROW)
                                           : (r_pix_base + A_ONE);

    // Sequencer FSM with all outputs, counters and incremental address bases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_kx        <= K_ZERO;
            r_ky        <= K_ZERO;
            r_c         <= C_ZERO;
            r_ox        <= OX_ZERO;
            r_oy        <= OY_ZERO;
            r_pix_base  <= A_ZERO;
            r_ifm_addr  <= A_ZERO;
            r_wgt_addr  <= A_ZERO;
            r_out_addr  <= A_ZERO;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_set_reg   <= 1'b0;
            r_pe_first  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            // SRAM data lands one cycle after the strobe, so the PE enable trails it.
            r_set_reg  <= r_rd_en;
            r_pe_first <= r_rd_en & w_first_tap;
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_rd_en    <= 1'b1;
                        r_kx       <= K_ZERO;
                        r_ky       <= K_ZERO;
                        r_c        <= C_ZERO;
                        r_ox       <= OX_ZERO;
                        r_oy       <= OY_ZERO;
                        r_pix_base <= A_ZERO;
                        r_ifm_addr <= A_ZERO;
                        r_wgt_addr <= A_ZERO;
                        r_out_addr <= A_ZERO;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_wgt_addr <= r_wgt_addr + A_ONE;
                    if (r_kx != K_LAST) begin
                        r_kx       <= r_kx + K_ONE;
                        r_ifm_addr <= r_ifm_addr + A_ONE;
                    end else if (r_ky != K_LAST) begin
                        r_kx       <= K_ZERO;
                        r_ky       <= r_ky + K_ONE;
                        r_ifm_addr <= r_ifm_addr + STEP_ROW;
                    end else if (r_c != C_LAST) begin
                        r_kx       <= K_ZERO;
                        r_ky       <= K_ZERO;
                        r_c        <= r_c + C_ONE;
                        r_ifm_addr <= r_ifm_addr + STEP_CH;
                    end else begin
                        r_kx    <= K_ZERO;
                        r_ky    <= K_ZERO;
                        r_c     <= C_ZERO;
                        r_rd_en <= 1'b0;
                        r_state <= S_LAT;
                    end
                end
                S_LAT: begin
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last_pix) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            if (r_ox == OX_LAST) begin
                                r_ox <= OX_ZERO;
                                r_oy <= r_oy + OY_ONE;
                            end else begin
                                r_ox <= r_ox + OX_ONE;
                            end
                            r_pix_base <= w_next_pix;
                            r_ifm_addr <= w_next_pix;
                            r_wgt_addr <= A_ZERO;
                            r_out_addr <= r_out_addr + A_ONE;
                            r_rd_en    <= 1'b1;
                            r_state    <= S_RUN;
                        end
                    end else begin
                        r_state <= S_OUT;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_rd_en     <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_en     = r_rd_en;
    assign ifm_addr  = r_ifm_addr;
    assign wgt_addr  = r_wgt_addr;
    assign set_reg   = r_set_reg;
    assign pe_first  = r_pe_first;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Randomized bench for conv_tap_sequencer with a window-arithmetic reference model,
// SRAM/PE models driven by the DUT, and a per-cycle compare process.
module tb_conv_tap_sequencer;
    localparam int K    = 3;
    localparam int W    = 5;
    localparam int H    = 4;
    localparam int CH   = 2;
    localparam int AW   = 12;
    localparam int OW   = W - K + 1;
    localparam int OH   = H - K + 1;
    localparam int NPIX = OW * OH;
    localparam int NTAP = K * K * CH;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] ifm_addr;
    logic [AW-1:0] wgt_addr;
    logic          set_reg;
    logic          pe_first;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;

    conv_tap_sequencer #(
        .K_SIZE(K), .IFM_W(W), .IFM_H(H), .CH(CH), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .ifm_addr(ifm_addr), .wgt_addr(wgt_addr),
        .set_reg(set_reg), .pe_first(pe_first), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  ifm_mem [0:4095];
    logic [7:0]  wgt_mem [0:4095];
    logic [7:0]  ifm_q;
    logic [7:0]  wgt_q;
    logic [31:0] psum;

    // Reference model state: tile active, finishing, pixel index, cycle within pixel.
    int m_active = 0;
    int m_fin    = 0;
    int m_pix    = 0;
    int m_pos    = 0;
    int pe_cnt   = 0;
    int acc_cnt  = 0;
    int last_psum = 0;
    int cap[$];
    int p0 [0:17];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int exp_ifm(input int pix, input int t);
        int kx, ky, c, ox, oy;
        kx = t % K;
        ky = (t / K) % K;
        c  = t / (K * K);
        ox = pix % OW;
        oy = pix / OW;
        return c * H * W + (oy + ky) * W + ox + kx;
    endfunction

    function automatic int exp_psum(input int pix);
        int s;
        s = 0;
        for (int t = 0; t < NTAP; t++)
            s += int'(ifm_mem[exp_ifm(pix, t)]) * int'(wgt_mem[t]);
        return s;
    endfunction

    // SRAMs with one-cycle read latency feeding a MAC PE.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifm_q <= 8'd0;
            wgt_q <= 8'd0;
            psum  <= 32'd0;
        end else begin
            if (rd_en) begin
                ifm_q <= ifm_mem[ifm_addr];
                wgt_q <= wgt_mem[wgt_addr];
            end
            if (set_reg)
                psum <= (pe_first ? 32'd0 : psum) + 32'(ifm_q) * 32'(wgt_q);
        end
    end

    initial begin : cmp
        int e_rd, e_set, e_first, e_ov;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_rd_en", int'(rd_en), 0);
                chk("rst_set_reg", int'(set_reg), 0);
                chk("rst_pe_first", int'(pe_first), 0);
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_ifm_addr", int'(ifm_addr), 0);
                chk("rst_wgt_addr", int'(wgt_addr), 0);
                chk("rst_out_addr", int'(out_addr), 0);
                m_active = 0; m_fin = 0; m_pix = 0; m_pos = 0;
            end else begin
                e_rd    = (m_active == 1 && m_pos < NTAP) ? 1 : 0;
                e_set   = (m_active == 1 && m_pos >= 1 && m_pos <= NTAP) ? 1 : 0;
                e_first = (m_active == 1 && m_pos == 1) ? 1 : 0;
                e_ov    = (m_active == 1 && m_pos >= NTAP + 1) ? 1 : 0;
                chk("busy", int'(busy), m_active);
                chk("done", int'(done), m_fin);
                chk("rd_en", int'(rd_en), e_rd);
                chk("set_reg", int'(set_reg), e_set);
                chk("pe_first", int'(pe_first), e_first);
                chk("out_valid", int'(out_valid), e_ov);
                if (e_rd == 1) begin
                    chk("ifm_addr", int'(ifm_addr), exp_ifm(m_pix, m_pos));
                    chk("wgt_addr", int'(wgt_addr), m_pos);
                end
                if (e_ov == 1) begin
                    chk("out_addr", int'(out_addr), m_pix);
                    chk("psum", int'(psum), exp_psum(m_pix));
                end
                if (rd_en && cap.size() < NTAP) cap.push_back(int'(ifm_addr));
                if (pe_first) pe_cnt++;
                if (m_fin == 1) begin
                    m_fin = 0;
                end else if (m_active == 0) begin
                    if (start) begin
                        m_active = 1; m_pix = 0; m_pos = 0;
                    end
                end else if (m_pos >= NTAP + 1) begin
                    if (out_ready) begin
                        acc_cnt++;
                        last_psum = int'(psum);
                        if (m_pix == NPIX - 1) begin
                            m_active = 0; m_fin = 1;
                        end else begin
                            m_pix++; m_pos = 0;
                        end
                    end
                end else begin
                    m_pos++;
                end
            end
        end
    end

    task automatic drive_rand();
        out_ready = ($urandom_range(0, 99) < 70);
        start     = ($urandom_range(0, 7) == 0);
    endtask

    task automatic wait_done(input bit rnd, output int n);
        n = 0;
        while (done !== 1'b1 && n < 4000) begin
            @(posedge clk); #1;
            n++;
            if (rnd) drive_rand();
            else start = 1'b0;
        end
        if (done !== 1'b1) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", n);
        end
    endtask

    initial begin : stim
        int n;
        p0 = '{0, 1, 2, 5, 6, 7, 10, 11, 12, 20, 21, 22, 25, 26, 27, 30, 31, 32};
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            ifm_mem[i] = 8'd1;
            wgt_mem[i] = 8'd1;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Tile 1: all-ones data, no backpressure, hand-computed pins.
        @(posedge clk); #1 start = 1'b1;
        wait_done(1'b0, n);
        chk("tile1_start_to_done", n, NPIX * (NTAP + 2) + 1);
        chk("tile1_start_to_done_lit", n, 121);
        chk("tile1_psum_lit", last_psum, 18);
        chk("tile1_pe_first_count", pe_cnt, 6);
        chk("tile1_pixels", acc_cnt, 6);
        chk("tile1_cap_size", cap.size(), 18);
        for (int i = 0; i < 18 && i < cap.size(); i++)
            chk("tile1_p0_ifm", cap[i], p0[i]);

        // Tile 2: random data, random backpressure and stray start pulses.
        for (int i = 0; i < 4096; i++) begin
            ifm_mem[i] = 8'($urandom_range(0, 255));
            wgt_mem[i] = 8'($urandom_range(0, 255));
        end
        @(posedge clk); #1 start = 1'b1;
        wait_done(1'b1, n);

        // Tile 3: start held through FIN, then reset during pixel 2.
        start = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!(m_active == 1 && m_pix == 2 && m_pos >= 2 && m_pos < NTAP - 2) && n < 4000) begin
            @(posedge clk); #1;
            n++;
            drive_rand();
        end
        if (n >= 4000) begin
            total++; bad++;
            $display("FAIL pix2_timeout: got no pixel-2 RUN, required one");
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_rd_en", int'(rd_en), 0);
        start = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // Tile 4: full rerun after the reset.
        @(posedge clk); #1 start = 1'b1;
        wait_done(1'b1, n);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
